// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter (and its future receiver).
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int calc_bps_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Even mode sends the XOR of the data bits, odd mode its inverse.
    function automatic logic calc_par(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_if.sv
// Byte-in / serial-out bundle between the buffering controller and uart_tx.
interface uart_if;
    logic [7:0] din;
    logic       din_vld;
    logic       busy;
    logic       tx;
    logic       overflow;

    modport master (output din, din_vld, input busy, tx, overflow);
    modport slave  (input din, din_vld, output busy, tx, overflow);
endinterface

// File: rtl/uart_baud_cnt.sv
// Enable-gated bit-period counter; o_bit_end pulses on the last clock of each bit.
module uart_baud_cnt #(
    parameter int BPS_CNT = 434
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_bit_end
);
    localparam int CW = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap    = (r_cnt == CW'(BPS_CNT - 1));
    assign o_bit_end = i_en && w_wrap;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter with a shifter plus one holding slot, so a byte
// arriving one cycle after busy was sampled low still fits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input logic   i_clk,
    input logic   i_rst,
    uart_if.slave bus
);
    localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, BAUD);

    uart_state_e r_state;
    logic [7:0]  r_shift;
    logic [7:0]  r_hold;
    logic        r_hold_vld;
    logic        r_par_bit;
    logic [2:0]  r_bit_idx;
    logic        r_stop_cnt;
    logic        r_tx;
    logic        r_busy;
    logic        r_ovf;

    logic w_bit_end;
    logic w_last_stop;
    logic w_shift_free;
    logic w_load_din;
    logic w_load_hold;
    logic w_hold_wr;
    logic w_drop;

    uart_baud_cnt #(.BPS_CNT(BPS_CNT)) u_baud (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (r_state != S_IDLE),
        .i_clr    (w_load_din && (r_state == S_IDLE)),
        .o_bit_end(w_bit_end)
    );

    // A slot frees on the edge that ends the final stop bit; the held byte has
    // priority for the shifter, so a new byte then lands in the holding slot.
    assign w_last_stop  = (r_state == S_STOP) && w_bit_end &&
                          (r_stop_cnt == 1'(STOP_BITS - 1));
    assign w_shift_free = (r_state == S_IDLE) || (w_last_stop && !r_hold_vld);
    assign w_load_din   = bus.din_vld && w_shift_free;
    assign w_load_hold  = w_last_stop && r_hold_vld;
    assign w_hold_wr    = bus.din_vld && !w_shift_free && (!r_hold_vld || w_last_stop);
    assign w_drop       = bus.din_vld && !w_shift_free && r_hold_vld && !w_last_stop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_par_bit  <= 1'b0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end

            if (w_hold_wr) begin
                r_hold     <= bus.din;
                r_hold_vld <= 1'b1;
            end else if (w_load_hold) begin
                r_hold_vld <= 1'b0;
            end

            if (w_load_din || w_load_hold) begin
                r_shift    <= w_load_din ? bus.din : r_hold;
                r_par_bit  <= calc_par(w_load_din ? bus.din : r_hold, PARITY);
                r_state    <= S_START;
                r_stop_cnt <= 1'b0;
                r_tx       <= 1'b0;
                r_busy     <= 1'b1;
            end else if (w_bit_end) begin
                case (r_state)
                    S_START: begin
                        r_state   <= S_DATA;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                    end
                    S_DATA: begin
                        if (r_bit_idx == 3'd7) begin
                            if (PARITY != PAR_NONE) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par_bit;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end
                    S_PARITY: begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end
                    S_STOP: begin
                        // Holding slot is empty here; otherwise the load branch won.
                        if (w_last_stop) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.tx       = r_tx;
    assign bus.busy     = r_busy;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three parity/stop configurations checked every cycle
// against a per-cycle line-waveform model, plus hand-computed spot checks.
module tb_uart_tx;
    localparam int BPS = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din [3];
    logic [2:0] vld;
    logic [2:0] tx_w, busy_w, ovf_w;

    uart_if uif0();
    uart_if uif1();
    uart_if uif2();

    assign uif0.din = din[0];  assign uif0.din_vld = vld[0];
    assign uif1.din = din[1];  assign uif1.din_vld = vld[1];
    assign uif2.din = din[2];  assign uif2.din_vld = vld[2];
    assign tx_w   = {uif2.tx, uif1.tx, uif0.tx};
    assign busy_w = {uif2.busy, uif1.busy, uif0.busy};
    assign ovf_w  = {uif2.overflow, uif1.overflow, uif0.overflow};

    uart_tx #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .PARITY(0), .STOP_BITS(1))
        dut0 (.i_clk(clk), .i_rst(rst), .bus(uif0));
    uart_tx #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .PARITY(2), .STOP_BITS(1))
        dut1 (.i_clk(clk), .i_rst(rst), .bus(uif1));
    uart_tx #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .PARITY(1), .STOP_BITS(2))
        dut2 (.i_clk(clk), .i_rst(rst), .bus(uif2));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: the line value for every remaining cycle of the current frame,
    // plus at most one waiting byte.
    logic       mw [3][256];
    int         wlen [3];
    int         wpos [3];
    int         nacc [3];
    logic       mhv  [3];
    logic [7:0] mhb  [3];
    logic       movf [3];

    function automatic int par_of(input int d);
        return (d == 1) ? 2 : (d == 2) ? 1 : 0;
    endfunction

    function automatic int stop_of(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    task automatic put(input int d, input logic v, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            mw[d][wlen[d]] = v;
            wlen[d]++;
        end
    endtask

    task automatic build(input int d, input logic [7:0] b);
        wlen[d] = 0;
        wpos[d] = 0;
        put(d, 1'b0, BPS);
        for (int i = 0; i < 8; i++) put(d, b[i], BPS);
        if (par_of(d) == 2) put(d, ^b, BPS);
        else if (par_of(d) == 1) put(d, ~^b, BPS);
        put(d, 1'b1, BPS * stop_of(d));
    endtask

    task automatic step(input int d);
        if (rst) begin
            wlen[d] = 0; wpos[d] = 0; mhv[d] = 1'b0; movf[d] = 1'b0;
        end else begin
            if (wpos[d] < wlen[d]) wpos[d]++;
            if (wpos[d] >= wlen[d] && mhv[d]) begin
                build(d, mhb[d]);
                mhv[d] = 1'b0;
            end
            if (vld[d]) begin
                if (wpos[d] >= wlen[d]) begin
                    build(d, din[d]); nacc[d]++;
                end else if (!mhv[d]) begin
                    mhb[d] = din[d]; mhv[d] = 1'b1; nacc[d]++;
                end else begin
                    movf[d] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic exp_tx(input int d);
        return (wpos[d] < wlen[d]) ? mw[d][wpos[d]] : 1'b1;
    endfunction

    function automatic logic exp_busy(input int d);
        return (wpos[d] < wlen[d]) || mhv[d];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            wlen[d] = 0; wpos[d] = 0; nacc[d] = 0; mhv[d] = 1'b0; mhb[d] = '0; movf[d] = 1'b0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 3; d++) step(d);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int d = 0; d < 3; d++) begin
                    chk($sformatf("cmp_tx%0d", d),   32'(tx_w[d]),   32'(exp_tx(d)));
                    chk($sformatf("cmp_busy%0d", d), 32'(busy_w[d]), 32'(exp_busy(d)));
                    chk($sformatf("cmp_ovf%0d", d),  32'(ovf_w[d]),  32'(movf[d]));
                end
            end
        end
    end

    logic [7:0] fq [$];
    logic [7:0] rd_dat;
    logic       rd_pend;
    int         budget;
    int         n0;

    initial begin
        rst = 1'b1; vld = '0;
        for (int d = 0; d < 3; d++) din[d] = 8'h00;
        tick(2);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_tx%0d", d),   32'(tx_w[d]),   32'd1);
            chk($sformatf("rst_busy%0d", d), 32'(busy_w[d]), 32'd0);
            chk($sformatf("rst_ovf%0d", d),  32'(ovf_w[d]),  32'd0);
        end
        rst = 1'b0;
        cmp_en = 1'b1;
        tick(3);

        // Single byte 0xA5, no parity, one stop bit
        din[0] = 8'hA5; vld[0] = 1'b1;
        tick(1); vld[0] = 1'b0;
        chk("A_start_tx", 32'(tx_w[0]), 32'd0);
        chk("A_start_busy", 32'(busy_w[0]), 32'd1);
        tick(9);  chk("A_k10_tx", 32'(tx_w[0]), 32'd0);
        tick(1);  chk("A_bit0", 32'(tx_w[0]), 32'd1);
        tick(10); chk("A_bit1", 32'(tx_w[0]), 32'd0);
        tick(10); chk("A_bit2", 32'(tx_w[0]), 32'd1);
        tick(40); chk("A_bit6", 32'(tx_w[0]), 32'd0);
        tick(20); chk("A_stop", 32'(tx_w[0]), 32'd1);
        tick(9);  chk("A_k100_busy", 32'(busy_w[0]), 32'd1);
        tick(1);  chk("A_k101_busy", 32'(busy_w[0]), 32'd0);
        chk("A_k101_tx", 32'(tx_w[0]), 32'd1);
        tick(5);

        // Two bytes on consecutive cycles: no idle gap, busy held high
        din[0] = 8'h55; vld[0] = 1'b1;
        tick(1); din[0] = 8'h0F;
        tick(1); vld[0] = 1'b0;
        for (int i = 0; i < 199; i++) begin
            chk("B_busy", 32'(busy_w[0]), 32'd1);
            if (i == 98) chk("B_last_stop", 32'(tx_w[0]), 32'd1);
            if (i == 99) chk("B_second_start", 32'(tx_w[0]), 32'd0);
            tick(1);
        end
        chk("B_busy_end", 32'(busy_w[0]), 32'd0);
        chk("B_ovf", 32'(ovf_w[0]), 32'd0);
        tick(3);

        // Three bytes on consecutive cycles: third dropped, overflow sticky
        din[0] = 8'h11; vld[0] = 1'b1;
        tick(1); din[0] = 8'h22;
        tick(1); din[0] = 8'h33;
        tick(1); vld[0] = 1'b0;
        chk("C_ovf_set", 32'(ovf_w[0]), 32'd1);
        tick(220);
        chk("C_ovf_sticky", 32'(ovf_w[0]), 32'd1);
        chk("C_idle_busy", 32'(busy_w[0]), 32'd0);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("C_ovf_cleared", 32'(ovf_w[0]), 32'd0);
        tick(3);

        // Parity and two stop bits on byte 0x07
        din[1] = 8'h07; din[2] = 8'h07; vld[1] = 1'b1; vld[2] = 1'b1;
        tick(1); vld[1] = 1'b0; vld[2] = 1'b0;
        tick(90);
        chk("D_even_par", 32'(tx_w[1]), 32'd1);
        chk("D_odd_par", 32'(tx_w[2]), 32'd0);
        tick(20);
        chk("D_even_done", 32'(busy_w[1]), 32'd0);
        chk("D_stop2_tx", 32'(tx_w[2]), 32'd1);
        chk("D_stop2_busy", 32'(busy_w[2]), 32'd1);
        tick(9);  chk("D_k120_busy", 32'(busy_w[2]), 32'd1);
        tick(1);  chk("D_k121_busy", 32'(busy_w[2]), 32'd0);
        tick(3);

        // Reset during data bit 3 with a byte waiting in the holding slot
        din[0] = 8'hC3; vld[0] = 1'b1;
        tick(1); din[0] = 8'h3C;
        tick(1); vld[0] = 1'b0;
        tick(42);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("E_rst_tx", 32'(tx_w[0]), 32'd1);
        chk("E_rst_busy", 32'(busy_w[0]), 32'd0);
        tick(150);
        chk("E_held_gone", 32'(busy_w[0]), 32'd0);
        din[0] = 8'h81; vld[0] = 1'b1;
        tick(1); vld[0] = 1'b0;
        chk("E_new_start", 32'(tx_w[0]), 32'd0);
        tick(100);
        chk("E_new_done", 32'(busy_w[0]), 32'd0);
        tick(3);

        // Controller emulation: busy gates a read, data follows one cycle later
        for (int i = 0; i < 8; i++) fq.push_back(8'(8'h30 + i));
        rd_pend = 1'b0; rd_dat = 8'h00;
        n0 = nacc[0];
        budget = 3000;
        while ((fq.size() > 0 || rd_pend || busy_w[0]) && budget > 0) begin
            vld[0] = rd_pend;
            din[0] = rd_dat;
            rd_pend = 1'b0;
            if (!busy_w[0] && fq.size() > 0) begin
                rd_dat = fq.pop_front();
                rd_pend = 1'b1;
            end
            tick(1);
            budget--;
        end
        vld[0] = 1'b0;
        chk("F_timeout", 32'(budget > 0), 32'd1);
        chk("F_frames", 32'(nacc[0] - n0), 32'd8);
        chk("F_ovf", 32'(ovf_w[0]), 32'd0);
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
